keypad_digit_display: RTL
=========================

Name: keypad_digit_display

Overview:
- Downstream consumer of the keypad scanner FSM.
- Accepts the scanner's 8-bit {cols,rows} key code and its one-cycle new-key strobe (the scanner's alarm output).
- Decodes each strobed code to a hex digit and keeps the two most recent digits in a shift history.
- Time-multiplexes the history onto a dual common-anode seven-segment display, with blanking dead-time between digit switches.

Parameters:
- REFRESH_CYCLES, 24000: int_osc cycles each digit is selected (500 us at 48 MHz). Must be >= 2.
- DEAD_CYCLES, 240: cycles at the start of each digit slot with both anodes off. Must be < REFRESH_CYCLES.

Ports:
- int_osc  in  1  system clock
- reset  in  1  synchronous, active-high reset
- keypress  in  8  key code {cols[3:0], rows[3:0]}, both nibbles active-low one-hot
- key_strobe  in  1  one-cycle pulse: keypress holds a newly debounced key
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low; seg[0]=a
- anode  out  2  digit enables, active-low; [0]=right/newest digit, [1]=left/older digit
- digits  out  8  {older, newest} hex history, for debug/LEDs
- new_digit  out  1  one-cycle pulse: history updated
- bad_key  out  1  one-cycle pulse: strobed code invalid

Behaviour:
- Reset (sync, high) clears state on the next int_osc edge:
  - digits=0, both valid flags=0, sel=0, phase counter=0.
  - seg=7'h7F, anode=2'b11, new_digit=0, bad_key=0.
  - Reset overrides a same-cycle key_strobe.
- Decode:
  - col index c=0..3 for cols 1110,1101,1011,0111.
  - row index r=0..3 for rows 1110,1101,1011,0111.
  - Map: r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: E 0 F D (indexed by c).
  - A nibble that is not exactly one zero is an invalid code.
- History update when key_strobe=1 at edge N:
  - Valid code: older<=newest, older_valid<=newest_valid, newest<=decoded, newest_valid<=1. new_digit=1 during cycle N+1.
  - Invalid code: history unchanged; bad_key=1 during cycle N+1.
  - Back-to-back strobes each shift independently; no strobe is dropped.
  - key_strobe=0: keypress is ignored.
- Refresh:
  - phase counter counts 0..REFRESH_CYCLES-1.
  - At terminal count it wraps to 0 and sel toggles.
  - sel=0 shows newest; sel=1 shows older.
- Outputs are registered, one cycle after counter/sel/history:
  - anode=2'b11 while phase<DEAD_CYCLES.
  - Otherwise anode=~(2'b01<<sel).
  - seg=~pattern(selected digit) if its valid flag is set, else 7'h7F (blank).
  - A history change appears on seg one cycle after the digits register changes, within the current slot.
- Patterns (active-high gfedcba):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- The refresh counter free-runs independently of key activity. Key events never reset the slot timing.
- Counter width is $clog2(REFRESH_CYCLES). No overflow beyond terminal count.

Test Plan (REFRESH_CYCLES=8, DEAD_CYCLES=2 unless noted):
- Reset, no keys, 40 cycles:
  - seg=7'h7F throughout.
  - anode cycles 11,11,10(x6),11,11,01(x6)...
  - digits=8'h00, no pulses.
- Strobe keypress=8'hDD ('5'):
  - next cycle new_digit=1, digits=8'h05.
  - in sel=0 slots past dead-time, seg=7'h12, anode=2'b10.
  - sel=1 slots: seg=7'h7F.
- Strobe 8'hEE ('1') then 8'h7E ('A') on consecutive cycles:
  - two new_digit pulses; digits=8'h1A.
  - right digit seg=7'h08, left digit seg=7'h79.
- Strobe invalid 8'hCE and 8'hFF with history 8'h1A:
  - bad_key pulses twice, new_digit stays 0, digits stays 8'h1A.
- Strobe 8'hD7 ('0') and 8'h7B ('C'); also all 16 valid codes:
  - decode 0 and C.
  - every hex value maps to the pattern table.
- Assert reset mid-slot with key_strobe=1 in the same cycle:
  - next cycle digits=0, seg=7'h7F, anode=2'b11, no new_digit.
  - refresh restarts from phase 0, sel=0.

Source files
------------

// File: rtl/keypad_digit_display.sv
// rtl/keypad_digit_display.sv - decodes keypad scanner codes into a two-digit hex history
// and time-multiplexes it onto a dual common-anode seven-segment display.
module keypad_digit_display #(
   parameter int REFRESH_CYCLES = 24000,
   parameter int DEAD_CYCLES    = 240
) (
   input  logic       int_osc,
   input  logic       reset,
   input  logic [7:0] keypress,
   input  logic       key_strobe,
   output logic [6:0] seg,
   output logic [1:0] anode,
   output logic [7:0] digits,
   output logic       new_digit,
   output logic       bad_key
);

   localparam int PW = $clog2(REFRESH_CYCLES);
   localparam logic [PW-1:0] LAST_PHASE = PW'(REFRESH_CYCLES - 1);
   localparam logic [PW-1:0] DEAD_PHASE = PW'(DEAD_CYCLES);

   logic [PW-1:0] phase;
   logic          sel;
   logic          newest_valid;
   logic          older_valid;

   logic [2:0] col_idx;
   logic [2:0] row_idx;
   logic       code_valid;
   logic [3:0] decoded;
   logic [3:0] shown;
   logic       shown_valid;

   // Returns {found, index}; found is clear unless exactly one bit is low.
   function automatic logic [2:0] nib_index(input logic [3:0] n);
      case (n)
         4'b1110: nib_index = 3'b100;
         4'b1101: nib_index = 3'b101;
         4'b1011: nib_index = 3'b110;
         4'b0111: nib_index = 3'b111;
         default: nib_index = 3'b000;
      endcase
   endfunction

   function automatic logic [3:0] key_value(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'h0: key_value = 4'h1;
         4'h1: key_value = 4'h2;
         4'h2: key_value = 4'h3;
         4'h3: key_value = 4'hA;
         4'h4: key_value = 4'h4;
         4'h5: key_value = 4'h5;
         4'h6: key_value = 4'h6;
         4'h7: key_value = 4'hB;
         4'h8: key_value = 4'h7;
         4'h9: key_value = 4'h8;
         4'hA: key_value = 4'h9;
         4'hB: key_value = 4'hC;
         4'hC: key_value = 4'hE;
         4'hD: key_value = 4'h0;
         4'hE: key_value = 4'hF;
         default: key_value = 4'hD;
      endcase
   endfunction

   // Active-high {g,f,e,d,c,b,a} pattern for a hex digit.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
      case (d)
         4'h0: hex_to_seg = 7'h3F;
         4'h1: hex_to_seg = 7'h06;
         4'h2: hex_to_seg = 7'h5B;
         4'h3: hex_to_seg = 7'h4F;
         4'h4: hex_to_seg = 7'h66;
         4'h5: hex_to_seg = 7'h6D;
         4'h6: hex_to_seg = 7'h7D;
         4'h7: hex_to_seg = 7'h07;
         4'h8: hex_to_seg = 7'h7F;
         4'h9: hex_to_seg = 7'h6F;
         4'hA: hex_to_seg = 7'h77;
         4'hB: hex_to_seg = 7'h7C;
         4'hC: hex_to_seg = 7'h39;
         4'hD: hex_to_seg = 7'h5E;
         4'hE: hex_to_seg = 7'h79;
         default: hex_to_seg = 7'h71;
      endcase
   endfunction

   always_comb begin
      col_idx     = nib_index(keypress[7:4]);
      row_idx     = nib_index(keypress[3:0]);
      code_valid  = col_idx[2] & row_idx[2];
      decoded     = key_value(row_idx[1:0], col_idx[1:0]);
      shown       = sel ? digits[7:4] : digits[3:0];
      shown_valid = sel ? older_valid : newest_valid;
   end

   always_ff @(posedge int_osc) begin
      if (reset) begin
         phase        <= '0;
         sel          <= 1'b0;
         digits       <= 8'h00;
         newest_valid <= 1'b0;
         older_valid  <= 1'b0;
         new_digit    <= 1'b0;
         bad_key      <= 1'b0;
         seg          <= 7'h7F;
         anode        <= 2'b11;
      end else begin
         if (phase == LAST_PHASE) begin
            phase <= '0;
            sel   <= ~sel;
         end else begin
            phase <= phase + PW'(1);
         end

         new_digit <= 1'b0;
         bad_key   <= 1'b0;
         if (key_strobe) begin
            if (code_valid) begin
               digits       <= {digits[3:0], decoded};
               older_valid  <= newest_valid;
               newest_valid <= 1'b1;
               new_digit    <= 1'b1;
            end else begin
               bad_key <= 1'b1;
            end
         end

         // Both anodes stay off for the first DEAD_CYCLES of every slot to avoid ghosting.
         anode <= (phase < DEAD_PHASE) ? 2'b11 : ~(2'b01 << sel);
         seg   <= shown_valid ? ~hex_to_seg(shown) : 7'h7F;
      end
   end

endmodule
